conversor_digitos: RTL and testbench

CONVERSOR_DIGITOS -- requirements
Module: conversor_digitos

---
 rtl/conversor_pkg.sv | 18 +
 rtl/ajuste_digito.sv | 9 +
 rtl/conversor_digitos.sv | 157 +++++++++++++++
 tb/tb_conversor_digitos.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conversor_pkg.sv
// Shared FSM states, radix codes and internal digit sizing for the binary-to-digits converter.
package conversor_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DESLOCA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   localparam logic MODO_OCTAL   = 1'b0;
   localparam logic MODO_DECIMAL = 1'b1;

   // One digit per 3 input bits covers both octal and BCD without overflow.
   function automatic int ndig_interno(input int largura);
      return (largura + 2) / 3;
   endfunction

endpackage

// File: rtl/ajuste_digito.sv
// Double-dabble correction: a BCD digit of 5 or more gets +3 so the next shift carries out correctly.
module ajuste_digito (
   input  logic [3:0] i_dig,
   output logic [3:0] o_dig
);

   assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/conversor_digitos.sv
// Binary to octal (result 1 cycle after accept) or BCD (LARGURA+1 cycles) converter; inicio ignored while busy.
// Optional macro CONVERSOR_SINAL_EN: two's-complement input, magnitude converted, sign on 'sinal'.
module conversor_digitos
   import conversor_pkg::*;
#(
   parameter int LARGURA = 8,
   parameter int NDIG    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inicio,
   input  logic                modo,
   input  logic [LARGURA-1:0]  entrada,
   output logic                ocupado,
   output logic                valido,
   output logic [4*NDIG-1:0]   digitos,
   output logic                estouro
`ifdef CONVERSOR_SINAL_EN
   ,
   output logic                sinal
`endif
);

   localparam int NINT = ndig_interno(LARGURA);
   localparam int NTOT = NINT + NDIG;
   localparam int CW   = $clog2(LARGURA);

   estado_t             r_estado;
   estado_t             w_prox;
   logic [LARGURA-1:0]  r_bin;
   logic [4*NINT-1:0]   r_bcd;
   logic [CW-1:0]       r_cont;
   logic [4*NDIG-1:0]   r_digitos;
   logic                r_estouro;

   logic                w_aceita;
   logic                w_ultimo;
   logic                w_carrega;
   logic [LARGURA-1:0]  w_mag;
   logic [3*NINT-1:0]   w_mag3;
   logic [4*NINT-1:0]   w_aj;
   logic [4*NINT:0]     w_oct;
   logic [4*NINT:0]     w_bcd_desl;
   logic [4*NINT:0]     w_res;
   logic [4*NTOT-1:0]   w_res_ext;

`ifdef CONVERSOR_SINAL_EN
   logic                w_neg;
   logic                r_neg;
   logic                r_sinal;

   assign w_neg = entrada[LARGURA-1];
   // -2^(LARGURA-1) negates to itself, which read unsigned is exactly its magnitude.
   assign w_mag = w_neg ? -entrada : entrada;
   assign sinal = r_sinal;
`else
   assign w_mag = entrada;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_prox;
      end
   end

   always_comb begin
      w_prox   = r_estado;
      ocupado  = 1'b0;
      valido   = 1'b0;
      w_aceita = 1'b0;
      w_ultimo = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (inicio) begin
               w_aceita = 1'b1;
               w_prox   = (modo == MODO_DECIMAL) ? DESLOCA : FIM;
            end
         end
         DESLOCA: begin
            ocupado = 1'b1;
            if (r_cont == CW'(LARGURA - 1)) begin
               w_ultimo = 1'b1;
               w_prox   = FIM;
            end
         end
         FIM: begin
            ocupado = 1'b1;
            valido  = 1'b1;
            w_prox  = OCIOSO;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   // Octal needs no iteration: regroup the magnitude 3 bits per digit.
   always_comb begin
      w_mag3                = '0;
      w_mag3[LARGURA-1:0]   = w_mag;
      w_oct                 = '0;
      for (int k = 0; k < NINT; k++) begin
         w_oct[4*k +: 4] = {1'b0, w_mag3[3*k +: 3]};
      end
   end

   for (genvar g = 0; g < NINT; g++) begin : g_ajuste
      ajuste_digito u_ajuste (
         .i_dig (r_bcd[4*g +: 4]),
         .o_dig (w_aj[4*g +: 4])
      );
   end

   assign w_bcd_desl = {w_aj, r_bin[LARGURA-1]};
   assign w_carrega  = (w_aceita && (modo == MODO_OCTAL)) || w_ultimo;
   assign w_res      = (r_estado == OCIOSO) ? w_oct : w_bcd_desl;
   // Bit 4*NINT (shifted out of the top digit) lands in the overflow region too.
   assign w_res_ext  = {{(4*NDIG-1){1'b0}}, w_res};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cont    <= '0;
         r_digitos <= '0;
         r_estouro <= 1'b0;
`ifdef CONVERSOR_SINAL_EN
         r_neg     <= 1'b0;
         r_sinal   <= 1'b0;
`endif
      end else begin
         if (w_aceita) begin
            r_bin  <= w_mag;
            r_bcd  <= '0;
            r_cont <= '0;
`ifdef CONVERSOR_SINAL_EN
            r_neg  <= w_neg;
`endif
         end else if (r_estado == DESLOCA) begin
            r_bin  <= r_bin << 1;
            r_bcd  <= w_bcd_desl[4*NINT-1:0];
            r_cont <= r_cont + CW'(1);
         end
         if (w_carrega) begin
            r_digitos <= w_res_ext[4*NDIG-1:0];
            r_estouro <= |w_res_ext[4*NTOT-1:4*NDIG];
`ifdef CONVERSOR_SINAL_EN
            r_sinal   <= (r_estado == OCIOSO) ? w_neg : r_neg;
`endif
         end
      end
   end

   assign digitos = r_digitos;
   assign estouro = r_estouro;

endmodule

// File: tb/tb_conversor_digitos.sv
// Bench for conversor_digitos: two instances (NDIG=3 and NDIG=2) share stimulus and are checked
// against an arithmetic divide/modulo reference model.
module tb_conversor_digitos;

   logic        clk;
   logic        reset;
   logic        inicio;
   logic        modo;
   logic [7:0]  entrada;

   logic        ocupado, valido, estouro;
   logic [11:0] digitos;
   logic        ocupado2, valido2, estouro2;
   logic [7:0]  digitos2;
`ifdef CONVERSOR_SINAL_EN
   logic        sinal, sinal2;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] prev3;
   logic [7:0]  prev2;
   logic        prev_e3, prev_e2;

   conversor_digitos #(.LARGURA(8), .NDIG(3)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .inicio  (inicio),
      .modo    (modo),
      .entrada (entrada),
      .ocupado (ocupado),
      .valido  (valido),
      .digitos (digitos),
      .estouro (estouro)
`ifdef CONVERSOR_SINAL_EN
      ,
      .sinal   (sinal)
`endif
   );

   conversor_digitos #(.LARGURA(8), .NDIG(2)) u_dut2 (
      .clk     (clk),
      .reset   (reset),
      .inicio  (inicio),
      .modo    (modo),
      .entrada (entrada),
      .ocupado (ocupado2),
      .valido  (valido2),
      .digitos (digitos2),
      .estouro (estouro2)
`ifdef CONVERSOR_SINAL_EN
      ,
      .sinal   (sinal2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: repeated division by the radix, low digit first.
   task automatic modelo(input logic m, input logic [7:0] e, input int nd,
                         output logic [11:0] dig, output logic est, output logic sg);
      int unsigned v;
      int unsigned base;
      v   = e;
      sg  = 1'b0;
`ifdef CONVERSOR_SINAL_EN
      if (e[7]) begin
         sg = 1'b1;
         v  = 256 - int'(e);
      end
`endif
      base = m ? 10 : 8;
      dig  = '0;
      for (int k = 0; k < nd; k++) begin
         dig[4*k +: 4] = 4'(v % base);
         v = v / base;
      end
      est = (v != 0);
   endtask

   // Starts in an OCIOSO cycle, returns at the negedge of the valido cycle.
   task automatic conv(input logic m, input logic [7:0] e, input int pulso);
      logic [11:0] d3, d2;
      logic        e3, e2, s3, s2;
      int          c;
      modelo(m, e, 3, d3, e3, s3);
      modelo(m, e, 2, d2, e2, s2);
      @(negedge clk);
      chk("idle_valido", 32'(valido), 0);
      chk("idle_ocupado", 32'(ocupado), 0);
      chk("hold_digitos", 32'(digitos), 32'(prev3));
      chk("hold_estouro2", 32'(estouro2), 32'(prev_e2));
      inicio  = 1'b1;
      modo    = m;
      entrada = e;
      @(negedge clk);
      inicio  = 1'b0;
      modo    = 1'($urandom);
      entrada = 8'($urandom);
      c = 1;
      while (!valido && c < 20) begin
         chk("ocupado_desloca", 32'(ocupado), 1);
         inicio = (c == pulso);
         @(negedge clk);
         c++;
      end
      inicio = 1'b0;
      chk("latencia", c, m ? 9 : 1);
      chk("valido2", 32'(valido2), 1);
      chk("ocupado_fim", 32'(ocupado), 1);
      chk("digitos", 32'(digitos), 32'(d3));
      chk("estouro", 32'(estouro), 32'(e3));
      chk("digitos2", 32'(digitos2), 32'(d2[7:0]));
      chk("estouro2", 32'(estouro2), 32'(e2));
`ifdef CONVERSOR_SINAL_EN
      chk("sinal", 32'(sinal), 32'(s3));
      chk("sinal2", 32'(sinal2), 32'(s2));
`endif
      prev3   = d3;
      prev2   = d2[7:0];
      prev_e3 = e3;
      prev_e2 = e2;
   endtask

   logic [7:0] cantos [5];
   int         gap;
   int         c;
   logic       m_r;
   logic [7:0] e_r;

   initial begin
      cantos  = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
      reset   = 1'b1;
      inicio  = 1'b0;
      modo    = 1'b0;
      entrada = '0;
      prev3   = '0;
      prev2   = '0;
      prev_e3 = 1'b0;
      prev_e2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ocupado", 32'(ocupado), 0);
      chk("rst_valido", 32'(valido), 0);
      chk("rst_digitos", 32'(digitos), 0);
      chk("rst_estouro", 32'(estouro), 0);
      chk("rst_digitos2", 32'(digitos2), 0);
      chk("rst_estouro2", 32'(estouro2), 0);
      reset = 1'b0;

      // Directed cases, each accepted in the OCIOSO cycle right after the previous FIM.
      conv(1'b1, 8'd255, 0);
      conv(1'b0, 8'd255, 0);
      conv(1'b1, 8'd0,   0);
      conv(1'b1, 8'd200, 0);
      conv(1'b1, 8'd99,  0);
      conv(1'b1, 8'd100, 3);
      conv(1'b0, 8'd0,   0);
      conv(1'b1, 8'h80,  0);
      conv(1'b0, 8'h80,  0);

      // Reset at T+4 of a decimal conversion, together with inicio.
      @(negedge clk);
      inicio  = 1'b1;
      modo    = 1'b1;
      entrada = 8'd77;
      @(negedge clk);
      inicio = 1'b0;
      for (c = 1; c < 4; c++) begin
         chk("abort_no_valido", 32'(valido), 0);
         @(negedge clk);
      end
      reset  = 1'b1;
      inicio = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      inicio = 1'b0;
      chk("abort_ocupado", 32'(ocupado), 0);
      chk("abort_valido", 32'(valido), 0);
      chk("abort_digitos", 32'(digitos), 0);
      chk("abort_estouro", 32'(estouro), 0);
      chk("abort_digitos2", 32'(digitos2), 0);
      prev3   = '0;
      prev2   = '0;
      prev_e3 = 1'b0;
      prev_e2 = 1'b0;
      repeat (12) begin
         @(negedge clk);
         chk("abort_sem_valido", 32'(valido), 0);
      end
      conv(1'b1, 8'd42, 0);

      for (int i = 0; i < 40; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         m_r = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) e_r = cantos[$urandom_range(0, 4)];
         else                           e_r = 8'($urandom);
         conv(m_r, e_r, (m_r && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0);
      end

      @(negedge clk);
      chk("final_valido", 32'(valido), 0);
      chk("final_digitos", 32'(digitos), 32'(prev3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
